hazard_forward_ctrl: RTL
========================

# hazard_forward_ctrl

Parametrised forwarding and hazard controller for the five-stage pipeline.
- Generates EX-stage and ID-stage operand forwarding selects.
- Detects load-use hazards and inserts a configurable number of bubbles through a countdown state machine.
- Freezes the pipeline while a load waits on data memory.
- Keeps a saturating stall-cycle counter.

It sits beside the ID/EX/MEM/WB pipeline registers and drives the operand muxes and the PC/IF-ID hold and ID/EX flush controls.

## Interface
- RW, 5, register index width
- CNT_W, 16, stall counter width
- LU_BUBBLES, 1, bubble cycles per load-use hazard (legal 1..7)

Clock and reset:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-low; Rst=0 clears all state

Instruction operand fields:
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RW  ID source registers
- id_rt_used  in  1  ID instruction reads rt (R-type or store)
- ex_rs, ex_rt  in  RW  EX source registers
- ex_rt_used  in  1  EX instruction reads rt

Writeback sources per stage:
- ex_regwrite, ex_is_load  in  1  EX writes ex_rd; EX is a load
- ex_rd  in  RW  EX destination
- mem_regwrite, mem_is_load, mem_ready  in  1  MEM writes mem_rd; MEM is a load; data memory returned this cycle
- mem_rd  in  RW  MEM destination
- wb_regwrite  in  1  WB writes wb_rd
- wb_rd  in  RW  WB destination

Control:
- stat_clr  in  1  synchronous clear of stall_cnt

Outputs:
- fwd_a, fwd_b  out  2  EX rs/rt select: 0 register file, 1 MEM, 2 WB (3 never driven)
- fwd_id_rs, fwd_id_rt  out  1  ID operand takes WB result
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX control fields
- freeze  out  1  hold every pipeline register
- stall_cnt  out  CNT_W  cycles with stall=1, saturating

## Operation
Forwarding (combinational):
- fwd_a: 1 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs. Else 2 if the same test holds for WB. Else 0.
- fwd_b: same rule against ex_rt, gated by ex_rt_used.
- fwd_id_rs = wb_regwrite & wb_rd!=0 & wb_rd==id_rs.
- fwd_id_rt = the same test against id_rt, gated by id_rt_used.
- Register 0 is never forwarded.

Hazard terms:
- mwait = mem_is_load & ~mem_ready.
- lu_hit = id_valid & ex_is_load & ex_regwrite & ex_rd!=0 & (ex_rd==id_rs | (id_rt_used & ex_rd==id_rt)).

FSM, states RUN and LU; a 3-bit countdown register cnt:
- RUN, mwait=1: freeze=1, stall=1, bubble=0. State and cnt hold.
- RUN, mwait=0, lu_hit=1: stall=1, bubble=1. If LU_BUBBLES>1, go to LU with cnt=LU_BUBBLES-1; else stay in RUN.
- RUN, otherwise: stall, bubble and freeze are 0.
- LU, mwait=1: freeze=1, stall=1, bubble=0. State and cnt hold.
- LU, mwait=0: stall=1, bubble=1, cnt decrements. Return to RUN when cnt is 1 before the decrement.
- lu_hit is ignored while in LU.
- freeze has priority over bubble in every state.

stall_cnt:
- Increments on every cycle with stall=1 (this includes freeze cycles).
- Saturates at 2^CNT_W-1.
- stat_clr=1 loads 0 that cycle and wins over increment.

## Timing
- Forwarding selects, stall, bubble and freeze are combinational from inputs and state, with zero-cycle latency.
- A load-use hazard yields exactly LU_BUBBLES cycles of bubble=1 with mwait=0; freeze cycles extend the sequence without consuming it.
- Rst low, at any time including mid-LU: state=RUN, cnt=0, stall_cnt=0.
- While Rst=0, stall, bubble and freeze are forced to 0; fwd_* continue to be evaluated from inputs.
- Release is synchronous to the first Clk edge with Rst=1.
- Simultaneous MEM and WB match to the same register: MEM wins.
- Simultaneous lu_hit and mwait: freeze only; lu_hit is re-evaluated once mwait clears.

## Test plan
- Forward priority: mem_rd=wb_rd=ex_rs=8, both regwrite=1 -> fwd_a=1. Drop mem_regwrite -> fwd_a=2. Set rd=0 -> fwd_a=0.
- rt gating: ex_rt=9=wb_rd, wb_regwrite=1, ex_rt_used=0 -> fwd_b=0. Set ex_rt_used=1 -> fwd_b=2. Same check on fwd_id_rt via id_rt_used.
- Load-use, LU_BUBBLES=3: ex_is_load, ex_rd=5, id_rs=5 -> stall=bubble=1 for exactly 3 cycles, then 0; stall_cnt=3.
- Memory wait: mem_is_load=1, mem_ready=0 for 4 cycles during LU with cnt=2 -> freeze=1, bubble=0 for those 4 cycles. After release, 2 more bubble cycles; stall_cnt advances by 6.
- Reset mid-LU: assert Rst=0 asynchronously -> stall, bubble, freeze and stall_cnt are 0 immediately. After release, the FSM is in RUN.
- Saturation and clear, CNT_W=4: hold a stall for 20 cycles -> stall_cnt=15. Pulse stat_clr alongside a stall -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding selects plus load-use / memory-wait stall control for a 5-stage pipeline.
// Zero-cycle combinational selects and stall/bubble/freeze; stall_cnt is registered and saturates.
module hazard_forward_ctrl #(
   parameter int RW         = 5,
   parameter int CNT_W      = 16,
   parameter int LU_BUBBLES = 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             id_valid,
   input  logic [RW-1:0]    id_rs,
   input  logic [RW-1:0]    id_rt,
   input  logic             id_rt_used,
   input  logic [RW-1:0]    ex_rs,
   input  logic [RW-1:0]    ex_rt,
   input  logic             ex_rt_used,
   input  logic             ex_regwrite,
   input  logic             ex_is_load,
   input  logic [RW-1:0]    ex_rd,
   input  logic             mem_regwrite,
   input  logic             mem_is_load,
   input  logic             mem_ready,
   input  logic [RW-1:0]    mem_rd,
   input  logic             wb_regwrite,
   input  logic [RW-1:0]    wb_rd,
   input  logic             stat_clr,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             fwd_id_rs,
   output logic             fwd_id_rt,
   output logic             stall,
   output logic             bubble,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {RUN, LU} state_t;

   localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);

   state_t     state;
   logic [2:0] cnt;
   logic       mem_fwd_ok;
   logic       wb_fwd_ok;
   logic       mwait;
   logic       lu_hit;
   logic       in_lu;

   assign mem_fwd_ok = mem_regwrite && (mem_rd != '0);
   assign wb_fwd_ok  = wb_regwrite && (wb_rd != '0);

   // MEM is younger than WB, so its result takes priority on a double match
   always_comb begin
      fwd_a = 2'd0;
      if (mem_fwd_ok && (mem_rd == ex_rs))
         fwd_a = 2'd1;
      else if (wb_fwd_ok && (wb_rd == ex_rs))
         fwd_a = 2'd2;

      fwd_b = 2'd0;
      if (ex_rt_used) begin
         if (mem_fwd_ok && (mem_rd == ex_rt))
            fwd_b = 2'd1;
         else if (wb_fwd_ok && (wb_rd == ex_rt))
            fwd_b = 2'd2;
      end
   end

   assign fwd_id_rs = wb_fwd_ok && (wb_rd == id_rs);
   assign fwd_id_rt = wb_fwd_ok && id_rt_used && (wb_rd == id_rt);

   assign mwait  = mem_is_load && !mem_ready;
   assign lu_hit = id_valid && ex_is_load && ex_regwrite && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_rt_used && (ex_rd == id_rt)));
   assign in_lu  = (state == LU);

   // Freeze overrides bubble; lu_hit is only looked at from RUN
   assign freeze = Rst && mwait;
   assign bubble = Rst && !mwait && (in_lu || lu_hit);
   assign stall  = Rst && (mwait || in_lu || lu_hit);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else if (!mwait) begin
         case (state)
            RUN: begin
               if (lu_hit && (LU_BUBBLES > 1)) begin
                  state <= LU;
                  cnt   <= LU_INIT;
               end
            end
            LU: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1)
                  state <= RUN;
            end
            default: begin
               state <= RUN;
               cnt   <= 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         stall_cnt <= '0;
      else if (stat_clr)
         stall_cnt <= '0;
      else if (stall && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule
